timer_core: RTL and testbench
=============================

TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 wr_en  input  1  single-cycle write qualifier from the APB interface stage (psel & penable & pwrite & pready).
REQ-004 rd_en  input  1  single-cycle read qualifier from the APB interface stage.
REQ-005 addr  input  12  byte address; bits[1:0] ignored.
REQ-006 wdata  input  32  write data.
REQ-007 pstrb  input  4  byte-lane write enables; pstrb[i] gates wdata[8i+7:8i].
REQ-008 rdata  output  32  read data.
REQ-009 tim_int  output  1  level interrupt.

Function
REQ-010 Register map SHALL be:
- 0x000 TCR: [0] timer_en, [1] div_en, [11:8] div_val; other bits 0.
- 0x004 TDR0 = cnt[31:0]; 0x008 TDR1 = cnt[63:32].
- 0x00C TCMP0, 0x010 TCMP1: 64-bit compare value.
- 0x014 TIER: [0] int_en.
- 0x018 TISR: [0] int_st, write-1-to-clear.
REQ-011 Unmapped addresses SHALL read 0; writes to them SHALL be ignored.
REQ-012 rdata SHALL be combinational: selected register when rd_en=1, else 0.
REQ-013 A TCR write whose resulting div_val > 8 SHALL be discarded entirely; TCR keeps its old value.
REQ-014 A write SHALL take effect on the clock edge where wr_en=1; a readback on the next cycle SHALL return the new value.
REQ-015 Prescaler: when div_en=0, the tick SHALL assert every cycle while timer_en=1; when div_en=1, it SHALL assert once every 2^div_val cycles.
REQ-016 The prescaler counter SHALL clear when timer_en=0, when div_en changes, or when div_val changes.
REQ-017 cnt SHALL increment by 1 on each tick and wrap 0xFFFF_FFFF_FFFF_FFFF -> 0 with no side effect.
REQ-018 A software write to TDR0/TDR1 SHALL take priority over a same-cycle increment; the written bytes replace cnt, other bytes keep pre-increment values.
REQ-019 Clearing timer_en SHALL freeze cnt; setting it again SHALL resume from the held value.
REQ-020 int_st SHALL be set on the edge after any cycle in which cnt == {TCMP1,TCMP0}, regardless of timer_en.
REQ-021 If a set condition and a W1C to int_st occur in the same cycle, the set SHALL win.
REQ-022 tim_int SHALL be int_en & int_st, driven combinationally from registered state.

Reset
REQ-023 While rst=1, all registers SHALL be 0 except TCMP0 and TCMP1, which SHALL be 0xFFFF_FFFF; tim_int=0, and rdata=0 unless rd_en=1.
REQ-024 rst asserted mid-count SHALL immediately clear cnt, the prescaler counter, and int_st.

Structure
REQ-025 Shared package timer_pkg SHALL hold the register offsets, reset values, and DIV_VAL_MAX=8.
REQ-026 Sub-module timer_cnt_div SHALL contain the prescaler and the 64-bit counter, with ports for tick, load strobes, and load data; register decode and interrupt logic SHALL stay in timer_core.

Verification
REQ-027 Reset and readback: after reset, read 0x00C -> 0xFFFF_FFFF; read 0x000 -> 0; tim_int=0.
REQ-028 Prescaler:
- write TCR=0x0000_0303 (div_val=3, enabled), run 80 cycles -> cnt=10 (±1).
- write TCR=0x0000_0903 -> TCR unchanged.
REQ-029 Wrap-around: load TDR1=0xFFFF_FFFF, TDR0=0xFFFF_FFFE, enable with div_en=0 -> cnt reads 0xFFFF_FFFF_FFFF_FFFF, then 0.
REQ-030 Interrupt:
- TCMP={0,5}, TIER=1, enable -> tim_int rises the cycle after cnt=5.
- W1C TISR=1 -> tim_int falls.
- W1C coinciding with a match -> int_st stays 1.
REQ-031 Byte strobes: with cnt=0x1122_3344 held, write TDR0 with wdata=0xAABB_CCDD and pstrb=4'b0101 -> TDR0=0x11BB_33DD.
REQ-032 Reset mid-count: assert rst at cnt=0x40 for one cycle -> cnt=0 and TCR=0; counting stays stopped afterward.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer: register offsets, reset values and
// the byte-strobe merge used by every software-writable register.
package timer_pkg;

  localparam logic [11:0] TCR_OFF   = 12'h000;
  localparam logic [11:0] TDR0_OFF  = 12'h004;
  localparam logic [11:0] TDR1_OFF  = 12'h008;
  localparam logic [11:0] TCMP0_OFF = 12'h00C;
  localparam logic [11:0] TCMP1_OFF = 12'h010;
  localparam logic [11:0] TIER_OFF  = 12'h014;
  localparam logic [11:0] TISR_OFF  = 12'h018;

  localparam logic [31:0] TCR_RST  = 32'h0000_0000;
  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;
  localparam logic        TIER_RST = 1'b0;
  localparam logic        TISR_RST = 1'b0;

  localparam logic [3:0] DIV_VAL_MAX = 4'd8;

  typedef struct packed {
    logic [3:0] div_val;
    logic       div_en;
    logic       timer_en;
  } tcr_t;

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    return res;
  endfunction

  function automatic logic [31:0] tcr_to_word(input tcr_t t);
    return {20'h0, t.div_val, 6'h0, t.div_en, t.timer_en};
  endfunction

  function automatic tcr_t word_to_tcr(input logic [31:0] w);
    tcr_t t;
    t.div_val  = w[11:8];
    t.div_en   = w[1];
    t.timer_en = w[0];
    return t;
  endfunction

endpackage

// File: rtl/timer_if.sv
// Register-bus bundle between the APB interface stage and the timer core.
interface timer_if;
  logic        wr_en;
  logic        rd_en;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  pstrb;
  logic [31:0] rdata;
  logic        tim_int;

  modport master (output wr_en, rd_en, addr, wdata, pstrb,
                  input  rdata, tim_int);
  modport slave  (input  wr_en, rd_en, addr, wdata, pstrb,
                  output rdata, tim_int);
endinterface

// File: rtl/timer_cnt_div.sv
// Power-of-two prescaler and the 64-bit free-running counter with
// per-half software load, where a load overrides the same-cycle increment.
module timer_cnt_div
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_en_i,
  input  logic        div_en_i,
  input  logic [3:0]  div_val_i,
  input  logic        ld_lo_i,
  input  logic        ld_hi_i,
  input  logic [31:0] ld_data_i,
  output logic        tick_o,
  output logic [63:0] cnt_o
);

  logic [7:0]  pre_q, pre_d;
  logic        div_en_q;
  logic [3:0]  div_val_q;
  logic [63:0] cnt_q, cnt_d;
  logic [8:0]  div_span;
  logic        cfg_chg;
  logic        pre_last;

  assign cfg_chg  = (div_en_i != div_en_q) || (div_val_i != div_val_q);
  assign div_span = (9'd1 << div_val_i) - 9'd1;
  assign pre_last = ({1'b0, pre_q} == div_span);
  // A divider reconfiguration restarts the period, so no divided tick that cycle.
  assign tick_o   = timer_en_i && (!div_en_i || (!cfg_chg && pre_last));
  assign cnt_o    = cnt_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pre_d = pre_q;
    if (!timer_en_i || !div_en_i || cfg_chg || pre_last)
      pre_d = 8'd0;
    else
      pre_d = pre_q + 8'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ld_lo_i || ld_hi_i) begin
      if (ld_lo_i) cnt_d[31:0]  = ld_data_i;
      if (ld_hi_i) cnt_d[63:32] = ld_data_i;
    end else if (tick_o) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= 8'd0;
      div_en_q  <= 1'b0;
      div_val_q <= 4'd0;
      cnt_q     <= 64'd0;
    end else begin
      pre_q     <= pre_d;
      div_en_q  <= div_en_i;
      div_val_q <= div_val_i;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_core.sv
// Timer register block: decode, compare-match interrupt and readback,
// wrapping the prescaler/counter sub-module.
module timer_core
  import timer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  timer_if.slave bus
);

  tcr_t        tcr_q, tcr_d, tcr_new;
  logic [31:0] tcmp0_q, tcmp0_d;
  logic [31:0] tcmp1_q, tcmp1_d;
  logic        int_en_q, int_en_d;
  logic        int_st_q, int_st_d;
  logic [11:0] word_addr;
  logic        wr_tcr, wr_tdr0, wr_tdr1, wr_tcmp0, wr_tcmp1, wr_tier, wr_tisr;
  logic        w1c, cmp_hit, tick;
  logic [63:0] cnt;
  logic [31:0] ld_data;
  logic        unused_ok;

  assign word_addr = {bus.addr[11:2], 2'b00};
  assign wr_tcr    = bus.wr_en && (word_addr == TCR_OFF);
  assign wr_tdr0   = bus.wr_en && (word_addr == TDR0_OFF);
  assign wr_tdr1   = bus.wr_en && (word_addr == TDR1_OFF);
  assign wr_tcmp0  = bus.wr_en && (word_addr == TCMP0_OFF);
  assign wr_tcmp1  = bus.wr_en && (word_addr == TCMP1_OFF);
  assign wr_tier   = bus.wr_en && (word_addr == TIER_OFF);
  assign wr_tisr   = bus.wr_en && (word_addr == TISR_OFF);

  assign tcr_new = word_to_tcr(apply_strobe(tcr_to_word(tcr_q), bus.wdata, bus.pstrb));
  assign w1c     = wr_tisr && bus.pstrb[0] && bus.wdata[0];
  assign cmp_hit = (cnt == {tcmp1_q, tcmp0_q});
  // Unwritten byte lanes of a counter load keep the pre-increment value.
  assign ld_data = wr_tdr0 ? apply_strobe(cnt[31:0],  bus.wdata, bus.pstrb)
                           : apply_strobe(cnt[63:32], bus.wdata, bus.pstrb);

  timer_cnt_div u_cnt_div (
    .clk        (clk),
    .rst        (rst),
    .timer_en_i (tcr_q.timer_en),
    .div_en_i   (tcr_q.div_en),
    .div_val_i  (tcr_q.div_val),
    .ld_lo_i    (wr_tdr0),
    .ld_hi_i    (wr_tdr1),
    .ld_data_i  (ld_data),
    .tick_o     (tick),
    .cnt_o      (cnt)
  );

  always_comb begin
    tcr_d    = tcr_q;
    tcmp0_d  = tcmp0_q;
    tcmp1_d  = tcmp1_q;
    int_en_d = int_en_q;
    if (wr_tcr && (tcr_new.div_val <= DIV_VAL_MAX)) tcr_d = tcr_new;
    if (wr_tcmp0) tcmp0_d = apply_strobe(tcmp0_q, bus.wdata, bus.pstrb);
    if (wr_tcmp1) tcmp1_d = apply_strobe(tcmp1_q, bus.wdata, bus.pstrb);
    if (wr_tier && bus.pstrb[0]) int_en_d = bus.wdata[0];
    // A match in the same cycle as a clear leaves the status set.
    int_st_d = cmp_hit || (int_st_q && !w1c);
  end

  // NOTE: every register, including the compare pair, has an explicit reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcr_q    <= word_to_tcr(TCR_RST);
      tcmp0_q  <= TCMP_RST;
      tcmp1_q  <= TCMP_RST;
      int_en_q <= TIER_RST;
      int_st_q <= TISR_RST;
    end else begin
      tcr_q    <= tcr_d;
      tcmp0_q  <= tcmp0_d;
      tcmp1_q  <= tcmp1_d;
      int_en_q <= int_en_d;
      int_st_q <= int_st_d;
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd_en) begin
      case (word_addr)
        TCR_OFF:   bus.rdata = tcr_to_word(tcr_q);
        TDR0_OFF:  bus.rdata = cnt[31:0];
        TDR1_OFF:  bus.rdata = cnt[63:32];
        TCMP0_OFF: bus.rdata = tcmp0_q;
        TCMP1_OFF: bus.rdata = tcmp1_q;
        TIER_OFF:  bus.rdata = {31'h0, int_en_q};
        TISR_OFF:  bus.rdata = {31'h0, int_st_q};
        default:   bus.rdata = 32'h0;
      endcase
    end
  end

  assign bus.tim_int = int_en_q && int_st_q;
  assign unused_ok   = ^{bus.addr[1:0], tick};

endmodule

// File: tb/tb_timer_core.sv
// Directed self-checking bench for timer_core: reset values, prescaler,
// byte strobes, freeze/resume, reset mid-count, wrap-around and interrupts.
module tb_timer_core;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;
  logic [31:0] rd;

  timer_if bus();

  timer_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.addr  = a;
    bus.wdata = d;
    bus.pstrb = s;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.pstrb = 4'h0;
  endtask

  task automatic rd_reg(input logic [11:0] a, output logic [31:0] d);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    #1;
    d = bus.rdata;
    bus.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = 12'h0;
    bus.wdata = 32'h0;
    bus.pstrb = 4'h0;

    // Reset state
    @(negedge clk);
    rd_reg(TCMP1_OFF, rd); check("rst_tcmp1_during", rd, 32'hFFFF_FFFF);
    check("rst_tim_int_during", bus.tim_int, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd_reg(TCMP0_OFF, rd); check("rst_tcmp0", rd, 32'hFFFF_FFFF);
    rd_reg(TCR_OFF, rd);   check("rst_tcr", rd, 32'h0);
    rd_reg(TDR0_OFF, rd);  check("rst_tdr0", rd, 32'h0);
    check("rst_tim_int", bus.tim_int, 1'b0);
    bus.addr = TCMP0_OFF; #1;
    check("rdata_idle_zero", bus.rdata, 32'h0);

    // Prescaler: divide by 8, about 10 ticks in 80 cycles
    @(negedge clk);
    wr(TCR_OFF, 32'h0000_0303, 4'hF);
    idle(80);
    rd_reg(TDR0_OFF, rd);
    total++;
    assert (rd >= 32'd9 && rd <= 32'd11) passed++;
    else begin
      failed++;
      $error("FAIL presc_cnt: observed %0d expected 10 +/- 1", rd);
    end
    rd_reg(TCR_OFF, rd); check("tcr_readback", rd, 32'h0000_0303);
    wr(TCR_OFF, 32'h0000_0903, 4'hF);
    rd_reg(TCR_OFF, rd); check("tcr_div_gt_max", rd, 32'h0000_0303);
    wr(12'h020, 32'hDEAD_BEEF, 4'hF);
    rd_reg(12'h020, rd); check("unmapped_rd", rd, 32'h0);
    wr(TCR_OFF, 32'h0, 4'hF);

    // Byte strobes on a held counter
    wr(TDR1_OFF, 32'h0, 4'hF);
    wr(TDR0_OFF, 32'h1122_3344, 4'hF);
    rd_reg(TDR0_OFF, rd); check("tdr0_load", rd, 32'h1122_3344);
    wr(TDR0_OFF, 32'hAABB_CCDD, 4'b0101);
    rd_reg(TDR0_OFF, rd); check("tdr0_strobe", rd, 32'h11BB_33DD);
    rd_reg(TDR1_OFF, rd); check("tdr1_untouched", rd, 32'h0);

    // Freeze and resume
    wr(TDR0_OFF, 32'h0000_003C, 4'hF);
    wr(TCR_OFF, 32'h1, 4'hF);
    wr(TCR_OFF, 32'h0, 4'hF);
    rd_reg(TDR0_OFF, rd); check("freeze_cnt", rd, 32'h3D);
    idle(5);
    rd_reg(TDR0_OFF, rd); check("freeze_hold", rd, 32'h3D);
    wr(TCR_OFF, 32'h1, 4'hF);
    idle(3);
    rd_reg(TDR0_OFF, rd); check("resume_cnt", rd, 32'h40);

    // Reset mid-count
    rst = 1'b1;
    #1;
    rd_reg(TDR0_OFF, rd); check("midrst_cnt", rd, 32'h0);
    rd_reg(TCR_OFF, rd);  check("midrst_tcr", rd, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    rd_reg(TDR0_OFF, rd); check("midrst_stopped", rd, 32'h0);

    // Wrap-around
    wr(TDR1_OFF, 32'hFFFF_FFFF, 4'hF);
    wr(TDR0_OFF, 32'hFFFF_FFFE, 4'hF);
    rd_reg(TDR0_OFF, rd); check("wrap_load", rd, 32'hFFFF_FFFE);
    wr(TCR_OFF, 32'h1, 4'hF);
    idle(1);
    rd_reg(TDR0_OFF, rd); check("wrap_max_lo", rd, 32'hFFFF_FFFF);
    rd_reg(TDR1_OFF, rd); check("wrap_max_hi", rd, 32'hFFFF_FFFF);
    idle(1);
    rd_reg(TDR0_OFF, rd); check("wrap_zero_lo", rd, 32'h0);
    rd_reg(TDR1_OFF, rd); check("wrap_zero_hi", rd, 32'h0);
    wr(TCR_OFF, 32'h0, 4'hF);
    rd_reg(TDR0_OFF, rd); check("wrap_stop", rd, 32'h1);
    rd_reg(TISR_OFF, rd); check("wrap_match_st", rd, 32'h1);
    check("wrap_int_masked", bus.tim_int, 1'b0);
    wr(TISR_OFF, 32'h1, 4'hF);
    rd_reg(TISR_OFF, rd); check("tisr_w1c", rd, 32'h0);

    // Compare interrupt
    wr(TDR0_OFF, 32'h0, 4'hF);
    wr(TCMP0_OFF, 32'h5, 4'hF);
    wr(TCMP1_OFF, 32'h0, 4'hF);
    wr(TIER_OFF, 32'h1, 4'hF);
    rd_reg(TIER_OFF, rd); check("tier_readback", rd, 32'h1);
    check("int_idle", bus.tim_int, 1'b0);
    wr(TCR_OFF, 32'h1, 4'hF);
    idle(5);
    rd_reg(TDR0_OFF, rd); check("int_cnt5", rd, 32'h5);
    check("int_not_yet", bus.tim_int, 1'b0);
    idle(1);
    check("int_rise", bus.tim_int, 1'b1);
    wr(TISR_OFF, 32'h1, 4'hF);
    check("int_fall", bus.tim_int, 1'b0);
    wr(TCR_OFF, 32'h0, 4'hF);

    // Clear coinciding with a match: set wins
    wr(TDR0_OFF, 32'h5, 4'hF);
    wr(TISR_OFF, 32'h1, 4'hF);
    rd_reg(TISR_OFF, rd); check("w1c_vs_set", rd, 32'h1);
    check("w1c_vs_set_int", bus.tim_int, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
